// File: rtl/timer_sequencer.sv
// timer_sequencer: fetches an interval length from an external time-parameter
// store and counts it down in one-second ticks, pulsing `expired` at the end.
//
// Ports:
//   clk            in   system clock, rising-edge active
//   Reset_N        in   asynchronous active-low reset
//   start_timer    in   level-sampled request to begin (or restart) an interval
//   interval_sel   in   00 tBASE, 01 tEXT, 10 tYEL, 11 2*tBASE
//   one_hz_enable  in   one-cycle tick, once per second
//   value          in   parameter read back from the store
//   time_selector  out  read address into the store
//   busy           out  high while fetching or counting
//   expired        out  one-cycle pulse at interval end
//   remaining      out  seconds left in the current interval
module timer_sequencer #(
  parameter int unsigned VALUE_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH = VALUE_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   Reset_N,
  input  logic                   start_timer,
  input  logic [1:0]             interval_sel,
  input  logic                   one_hz_enable,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic [1:0]             time_selector,
  output logic                   busy,
  output logic                   expired,
  output logic [COUNT_WIDTH-1:0] remaining
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch1,
    StFetch2,
    StCount,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  logic [1:0]             tsel_q, tsel_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [COUNT_WIDTH-1:0] value_ext;
  logic [COUNT_WIDTH-1:0] load_val;
  logic [1:0]             start_addr;

  // 2*tBASE reads the tBASE slot and doubles it at load time.
  assign start_addr = (interval_sel == 2'b11) ? 2'b00 : interval_sel;
  assign value_ext  = COUNT_WIDTH'(value);
  assign load_val   = (sel_q == 2'b11) ? (value_ext << 1) : value_ext;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tsel_d  = tsel_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (start_timer) begin
          sel_d   = interval_sel;
          tsel_d  = start_addr;
          state_d = StFetch1;
        end
      end
      // Two fetch cycles so a registered store output has settled by FETCH2.
      StFetch1: state_d = StFetch2;
      StFetch2: begin
        rem_d   = load_val;
        state_d = StCount;
      end
      StCount: begin
        if (start_timer) begin
          // Restart: abandon the current interval silently.
          sel_d   = interval_sel;
          tsel_d  = start_addr;
          state_d = StFetch1;
        end else if (rem_q == '0) begin
          // Zero-length interval finishes without waiting for a tick.
          state_d = StDone;
        end else if (one_hz_enable) begin
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (rem_q == COUNT_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= StIdle;
      sel_q   <= 2'b00;
      tsel_q  <= 2'b00;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tsel_q  <= tsel_d;
      rem_q   <= rem_d;
    end
  end

  assign time_selector = tsel_q;
  assign remaining     = rem_q;
  assign busy          = (state_q == StFetch1) || (state_q == StFetch2) || (state_q == StCount);
  assign expired       = (state_q == StDone);

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer. A small combinational store model
// answers time_selector reads; expected interval lengths are queued when an
// interval is started and popped when expired is observed.
module tb_timer_sequencer;

  logic       clk;
  logic       Reset_N;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic       one_hz_enable;
  logic [3:0] value;
  logic [1:0] time_selector;
  logic       busy;
  logic       expired;
  logic [4:0] remaining;

  logic [3:0] store [4];
  int         exp_q [$];
  int         checks;
  int         errors;

  timer_sequencer dut (
    .clk           (clk),
    .Reset_N       (Reset_N),
    .start_timer   (start_timer),
    .interval_sel  (interval_sel),
    .one_hz_enable (one_hz_enable),
    .value         (value),
    .time_selector (time_selector),
    .busy          (busy),
    .expired       (expired),
    .remaining     (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb value = store[time_selector];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] sel);
    interval_sel = sel;
    start_timer  = 1'b1;
    cycle();
    start_timer  = 1'b0;
  endtask

  function automatic int model_load(input logic [1:0] sel);
    if (sel == 2'b11) return 2 * int'(store[0]);
    return int'(store[sel]);
  endfunction

  // Ticks every third cycle until expired; checks remaining each cycle.
  task automatic count_down(input int max_cycles, input bit start_in_done);
    int ticks;
    int exp_ticks;
    int exp_rem;
    bit seen;
    logic [1:0] ts_before;
    ticks = 0;
    seen  = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
      return;
    end
    exp_ticks = exp_q.pop_front();
    exp_rem   = exp_ticks;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      one_hz_enable = (c % 3 == 2);
      cycle();
      if (one_hz_enable) begin
        ticks++;
        if (exp_rem > 0) exp_rem--;
      end
      one_hz_enable = 1'b0;
      if (expired) begin
        seen = 1'b1;
        checks++;
        if (ticks !== exp_ticks) begin
          errors++;
          $display("FAIL expire_ticks: got %0d ticks, required %0d", ticks, exp_ticks);
        end
        checks++;
        if (remaining !== 5'd0) begin
          errors++;
          $display("FAIL expire_remaining: got %0d, required 0", remaining);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL expire_busy: got %0b, required 0", busy);
        end
      end else begin
        checks++;
        if (remaining !== 5'(exp_rem)) begin
          errors++;
          $display("FAIL count_remaining: got %0d, required %0d", remaining, exp_rem);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL expire_timeout: got no expired within %0d cycles, required %0d ticks",
               max_cycles, exp_ticks);
      return;
    end
    ts_before = time_selector;
    if (start_in_done) begin
      interval_sel = 2'b01;
      start_timer  = 1'b1;
    end
    cycle();
    start_timer = 1'b0;
    checks++;
    if (expired !== 1'b0) begin
      errors++;
      $display("FAIL expire_one_cycle: got %0b, required 0", expired);
    end
    if (start_in_done) begin
      checks++;
      if (busy !== 1'b0 || time_selector !== ts_before) begin
        errors++;
        $display("FAIL done_start_ignored: got busy %0b sel %0d, required busy 0 sel %0d",
                 busy, time_selector, ts_before);
      end
      cycle();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_start_idle: got busy %0b, required 0", busy);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || expired !== 1'b0 || remaining !== 5'd0 || time_selector !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got busy %0b exp %0b rem %0d sel %0d, required 0 0 0 0",
               busy, expired, remaining, time_selector);
    end
    #11;
    Reset_N = 1'b1;
    cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy %0b, required 0", busy);
    end
  endtask

  task automatic test_base();
    store[0] = 4'd6;
    exp_q.push_back(model_load(2'b00));
    start(2'b00);
    checks++;
    if (time_selector !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL base_start: got sel %0d busy %0b, required 0 1", time_selector, busy);
    end
    cycle();
    cycle();
    checks++;
    if (remaining !== 5'd6) begin
      errors++;
      $display("FAIL base_load: got %0d, required 6", remaining);
    end
    count_down(60, 1'b0);
  endtask

  task automatic test_double();
    store[0] = 4'd6;
    exp_q.push_back(model_load(2'b11));
    start(2'b11);
    checks++;
    if (time_selector !== 2'b00) begin
      errors++;
      $display("FAIL double_sel: got %0d, required 0", time_selector);
    end
    cycle();
    cycle();
    checks++;
    if (remaining !== 5'd12) begin
      errors++;
      $display("FAIL double_load: got %0d, required 12", remaining);
    end
    count_down(60, 1'b0);
  endtask

  task automatic test_zero();
    store[2] = 4'd0;
    exp_q.push_back(model_load(2'b10));
    start(2'b10);
    cycle();
    cycle();
    checks++;
    if (remaining !== 5'd0 || busy !== 1'b1 || time_selector !== 2'b10) begin
      errors++;
      $display("FAIL zero_load: got rem %0d busy %0b sel %0d, required 0 1 2",
               remaining, busy, time_selector);
    end
    count_down(5, 1'b0);
  endtask

  task automatic test_restart();
    store[1] = 4'd3;
    store[2] = 4'd4;
    start(2'b01);
    cycle();
    cycle();
    one_hz_enable = 1'b1;
    cycle();
    one_hz_enable = 1'b0;
    checks++;
    if (remaining !== 5'd2) begin
      errors++;
      $display("FAIL restart_pre: got %0d, required 2", remaining);
    end
    exp_q.push_back(model_load(2'b10));
    start(2'b10);
    checks++;
    if (expired !== 1'b0 || time_selector !== 2'b10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_abort: got exp %0b sel %0d busy %0b, required 0 2 1",
               expired, time_selector, busy);
    end
    cycle();
    checks++;
    if (expired !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_expire: got %0b, required 0", expired);
    end
    cycle();
    checks++;
    if (remaining !== 5'd4) begin
      errors++;
      $display("FAIL restart_load: got %0d, required 4", remaining);
    end
    count_down(30, 1'b0);
  endtask

  task automatic test_ignore();
    store[0] = 4'd2;
    store[1] = 4'd9;
    exp_q.push_back(model_load(2'b00));
    start(2'b00);
    // start and ticks during the fetch cycles must not matter
    interval_sel  = 2'b01;
    start_timer   = 1'b1;
    one_hz_enable = 1'b1;
    cycle();
    cycle();
    start_timer   = 1'b0;
    one_hz_enable = 1'b0;
    checks++;
    if (remaining !== 5'd2 || time_selector !== 2'b00) begin
      errors++;
      $display("FAIL fetch_ignore: got rem %0d sel %0d, required 2 0", remaining, time_selector);
    end
    count_down(20, 1'b1);
  endtask

  task automatic test_reset_mid();
    store[2] = 4'd6;
    start(2'b10);
    cycle();
    cycle();
    one_hz_enable = 1'b1;
    cycle();
    one_hz_enable = 1'b0;
    checks++;
    if (remaining !== 5'd5) begin
      errors++;
      $display("FAIL reset_mid_pre: got %0d, required 5", remaining);
    end
    #1;
    Reset_N = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || expired !== 1'b0 || remaining !== 5'd0 || time_selector !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_clear: got busy %0b exp %0b rem %0d sel %0d, required 0 0 0 0",
               busy, expired, remaining, time_selector);
    end
    #3;
    Reset_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      one_hz_enable = 1'b1;
      cycle();
      checks++;
      if (busy !== 1'b0 || expired !== 1'b0 || remaining !== 5'd0) begin
        errors++;
        $display("FAIL reset_mid_quiet: got busy %0b exp %0b rem %0d, required 0 0 0",
                 busy, expired, remaining);
      end
    end
    one_hz_enable = 1'b0;
    exp_q.push_back(model_load(2'b10));
    start(2'b10);
    cycle();
    cycle();
    checks++;
    if (remaining !== 5'd6) begin
      errors++;
      $display("FAIL reset_mid_resume: got %0d, required 6", remaining);
    end
    count_down(40, 1'b0);
  endtask

  task automatic test_reprogram();
    store[0] = 4'd6;
    exp_q.push_back(6);
    start(2'b00);
    cycle();
    cycle();
    store[0] = 4'd15;
    count_down(40, 1'b0);
    exp_q.push_back(model_load(2'b00));
    start(2'b00);
    cycle();
    cycle();
    checks++;
    if (remaining !== 5'd15) begin
      errors++;
      $display("FAIL reprogram_next: got %0d, required 15", remaining);
    end
    count_down(60, 1'b0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    Reset_N       = 1'b0;
    start_timer   = 1'b0;
    interval_sel  = 2'b00;
    one_hz_enable = 1'b0;
    for (int i = 0; i < 4; i++) store[i] = 4'd0;
    test_reset();
    test_base();
    test_double();
    test_zero();
    test_restart();
    test_ignore();
    test_reset_mid();
    test_reprogram();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d entries, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
